// File: rtl/differentiator_pkg.sv
// ============================================================================
// differentiator_pkg : shared mode constants for the arithmetic blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package differentiator_pkg;

  localparam int c_MODE_WRAP     = 0;
  localparam int c_MODE_SATURATE = 1;

endpackage

`default_nettype wire

// File: rtl/diff_saturate.sv
// ============================================================================
// diff_saturate : narrows a (W+1)-bit difference to W bits, wrap or clamp
// Rev 1.0
// ============================================================================
`default_nettype none

module diff_saturate
  import differentiator_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_SATURATE   = c_MODE_WRAP
) (
  input  logic signed [p_DATA_WIDTH:0]   i_DIFF,
  output logic signed [p_DATA_WIDTH-1:0] o_RESULT,
  output logic                           o_OVERFLOW
);

  localparam logic signed [p_DATA_WIDTH-1:0] c_MAX = {1'b0, {(p_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [p_DATA_WIDTH-1:0] c_MIN = {1'b1, {(p_DATA_WIDTH-1){1'b0}}};

  logic w_overflow;

  // The value fits exactly when the two top bits agree.
  assign w_overflow = i_DIFF[p_DATA_WIDTH] ^ i_DIFF[p_DATA_WIDTH-1];
  assign o_OVERFLOW = w_overflow;

  always_comb begin
    o_RESULT = i_DIFF[p_DATA_WIDTH-1:0];
    if ((p_SATURATE == c_MODE_SATURATE) && w_overflow) begin
      o_RESULT = i_DIFF[p_DATA_WIDTH] ? c_MIN : c_MAX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/differentiator.sv
// ============================================================================
// differentiator : first difference of a sample stream, valid/ready handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module differentiator
  import differentiator_pkg::*;
#(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_SATURATE   = c_MODE_WRAP
) (
  input  logic                           i_CLK,
  input  logic                           i_RESET_N,
  input  logic                           i_CLK_ENABLE,
  input  logic                           i_CLEAR,
  input  logic                           i_VALID,
  output logic                           o_READY,
  input  logic signed [p_DATA_WIDTH-1:0] i_SAMPLE,
  output logic                           o_VALID,
  input  logic                           i_READY,
  output logic signed [p_DATA_WIDTH-1:0] o_DIFFERENCE,
  output logic                           o_OVERFLOW
);

  logic signed [p_DATA_WIDTH-1:0] r_prev;
  logic signed [p_DATA_WIDTH-1:0] r_difference;
  logic                           r_overflow;
  logic                           r_valid;

  logic                           w_ready;
  logic                           w_accept;
  logic                           w_transfer;
  logic signed [p_DATA_WIDTH-1:0] w_prev;
  logic signed [p_DATA_WIDTH:0]   w_sample_ext;
  logic signed [p_DATA_WIDTH:0]   w_prev_ext;
  logic signed [p_DATA_WIDTH:0]   w_diff;
  logic signed [p_DATA_WIDTH-1:0] w_result;
  logic                           w_overflow;

  assign w_ready    = i_CLK_ENABLE & (~r_valid | i_READY);
  assign w_accept   = i_VALID & w_ready;
  assign w_transfer = i_CLK_ENABLE & r_valid & i_READY;

  // A clear on the accepting edge makes that sample difference against zero.
  assign w_prev       = i_CLEAR ? '0 : r_prev;
  assign w_sample_ext = {i_SAMPLE[p_DATA_WIDTH-1], i_SAMPLE};
  assign w_prev_ext   = {w_prev[p_DATA_WIDTH-1], w_prev};
  assign w_diff       = w_sample_ext - w_prev_ext;

  diff_saturate #(
    .p_DATA_WIDTH (p_DATA_WIDTH),
    .p_SATURATE   (p_SATURATE)
  ) u_diff_saturate (
    .i_DIFF     (w_diff),
    .o_RESULT   (w_result),
    .o_OVERFLOW (w_overflow)
  );

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_prev       <= '0;
      r_difference <= '0;
      r_overflow   <= 1'b0;
      r_valid      <= 1'b0;
    end else if (i_CLK_ENABLE) begin
      if (w_accept) begin
        r_prev       <= i_SAMPLE;
        r_difference <= w_result;
        r_overflow   <= w_overflow;
        r_valid      <= 1'b1;
      end else begin
        if (i_CLEAR) begin
          r_prev <= '0;
        end
        if (w_transfer) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign o_READY      = w_ready;
  assign o_VALID      = r_valid;
  assign o_DIFFERENCE = r_difference;
  assign o_OVERFLOW   = r_overflow;

endmodule

`default_nettype wire

// File: doc/differentiator.md
DIFFERENTIATOR -- requirements
Module: differentiator

Interface
REQ-001 SHALL have parameter p_DATA_WIDTH, default 8, setting the bit width of the sample and difference ports.
REQ-002 SHALL have parameter p_SATURATE, default 0: 0 = wrap mode (exact inverse of a wrapping accumulator), 1 = saturate mode.
REQ-003 SHALL have port i_CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port i_RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_CLK_ENABLE  input  1  clock enable, active high; when low, no state changes.
REQ-006 SHALL have port i_CLEAR  input  1  synchronous clear of the stored previous sample, active high.
REQ-007 SHALL have port i_VALID  input  1  upstream sample valid.
REQ-008 SHALL have port o_READY  output  1  block can accept a sample.
REQ-009 SHALL have port i_SAMPLE  input  p_DATA_WIDTH  signed incoming sample (an accumulation value).
REQ-010 SHALL have port o_VALID  output  1  o_DIFFERENCE holds an untransferred result.
REQ-011 SHALL have port i_READY  input  1  downstream can accept a result.
REQ-012 SHALL have port o_DIFFERENCE  output  p_DATA_WIDTH  signed registered difference.
REQ-013 SHALL have port o_OVERFLOW  output  1  registered flag: the true difference did not fit in p_DATA_WIDTH; qualified by o_VALID.

Function
REQ-014 SHALL compute d = i_SAMPLE - prev, where prev is the last accepted sample; prev is 0 after reset or clear.
REQ-015 SHALL evaluate d at p_DATA_WIDTH+1 bits and set o_OVERFLOW when d is outside the signed p_DATA_WIDTH range.
REQ-016 SHALL, in wrap mode, output the low p_DATA_WIDTH bits of d; in saturate mode, clamp d to the signed maximum or minimum.
REQ-017 SHALL drive o_READY = i_CLK_ENABLE and (not o_VALID or i_READY); combinational, with no dependency on i_VALID.
REQ-018 SHALL accept a sample on a clock edge with i_VALID, o_READY, and i_CLK_ENABLE all high, then update prev to i_SAMPLE.
REQ-019 SHALL present each result on o_DIFFERENCE/o_OVERFLOW with o_VALID high on the edge after acceptance (latency 1).
REQ-020 SHALL complete an output transfer on an edge with o_VALID, i_READY, and i_CLK_ENABLE all high; without a same-edge acceptance, o_VALID falls.
REQ-021 SHALL support full throughput of one sample per cycle when a transfer and an acceptance coincide.
REQ-022 SHALL hold o_DIFFERENCE, o_OVERFLOW, and o_VALID stable while o_VALID is high and i_READY is low.
REQ-023 SHALL, on i_CLEAR with i_CLK_ENABLE high, set prev to 0; if a sample is accepted on the same edge, compute it against 0 and then store it as prev.
REQ-024 SHALL leave a pending result untouched when i_CLEAR is asserted.
REQ-025 SHALL ignore i_SAMPLE and i_CLEAR on edges where i_CLK_ENABLE is low.

Reset
REQ-026 SHALL, while i_RESET_N is low, immediately drive o_VALID=0, o_DIFFERENCE=0, o_OVERFLOW=0, and prev=0, independent of i_CLK.
REQ-027 SHALL discard any pending result when reset is asserted mid-operation.
REQ-028 SHALL accept a sample on the first enabled edge after i_RESET_N rises.

Structure
REQ-029 SHALL place the mode constants (wrap = 0, saturate = 1) in the shared include file used by the arithmetic blocks.
REQ-030 SHALL implement the clamp/overflow logic as one combinational sub-module named diff_saturate; all registers SHALL stay in differentiator.

Verification (p_DATA_WIDTH=8)
REQ-031 SHALL verify basic differencing: after reset, feed 5, 12, 10 with i_READY=1 -> outputs 5, 7, -2, each one cycle after acceptance, with o_OVERFLOW=0.
REQ-032 SHALL verify overflow handling: prev=100, feed -100 -> wrap mode outputs 56 with o_OVERFLOW=1; saturate mode outputs -128 with o_OVERFLOW=1.
REQ-033 SHALL verify backpressure: result 7 pending with i_READY=0 for 3 cycles -> o_READY=0 and output held at 7; raising i_READY transfers it once.
REQ-034 SHALL verify clear: prev=40, pulse i_CLEAR, then feed 3 -> output 3; also clear and sample 9 on the same edge -> output 9 and prev=9.
REQ-035 SHALL verify asynchronous reset mid-operation: drop i_RESET_N between edges while o_VALID=1 -> o_VALID=0 and o_DIFFERENCE=0 immediately; next sample 4 -> output 4.
REQ-036 SHALL verify round trip in wrap mode: feed the accumulator's output stream driven by summands {3, -7, 127, 1} -> reproduces 3, -7, 127, 1.
